mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single external memory interface between the instruction cache and the data cache. It sits between both `cache` instances' `mem_req_*` / `mem_resp_*` ports and the memory model. It grants one whole line transaction at a time: one read command plus 4 response beats, or 4 write beats. Responses are routed back only to the granted cache.

## Interface
Parameters:
- MEM_ADDR_BITS, default 28: line-granular memory address width (`CPU_ADDR_BITS` minus 4).
- DATA_BITS, default `MEM_DATA_BITS` (128): beat width.
- BEATS, default 4: beats per line transaction; must be a power of 2.

Ports (icache requester uses prefix `ic_`, dcache requester uses prefix `dc_`; both sets are identical):
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- {ic,dc}_mem_req_valid  in  1  command / write-beat valid.
- {ic,dc}_mem_req_ready  out  1  command accepted.
- {ic,dc}_mem_req_addr  in  MEM_ADDR_BITS  line address.
- {ic,dc}_mem_req_rw  in  1  1 = write, 0 = read.
- {ic,dc}_mem_req_data_valid  in  1  write data valid.
- {ic,dc}_mem_req_data_ready  out  1  write data accepted.
- {ic,dc}_mem_req_data_bits  in  DATA_BITS  write data.
- {ic,dc}_mem_req_data_mask  in  DATA_BITS/8  byte mask.
- {ic,dc}_mem_resp_valid  out  1  read beat for this requester.
- {ic,dc}_mem_resp_data  out  DATA_BITS  read beat data; both ports carry the memory data unconditionally.
- mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask  out  memory side, same widths as above.
- mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data  in  memory side.
- err_stray_resp  out  1  sticky; set when mem_resp_valid arrives outside RD_WAIT.

## Operation
- States: IDLE, CMD, RD_WAIT, WR_BURST.
- owner register: 0 = ic, 1 = dc. beat_cnt register: log2(BEATS) bits.
- IDLE:
  - If no request is pending, stay in IDLE and drive all memory-side valids to 0.
  - If one requester has req_valid, latch it as owner.
  - If both have req_valid, the picker chooses the owner.
  - Then go to CMD.
- CMD:
  - Forward the owner's req fields to memory. The non-owner sees ready = 0, data_ready = 0 and resp_valid = 0.
  - Owner's req_ready = mem_req_ready. Owner's data_ready = mem_req_data_ready.
  - Read accept is `valid & ready & !rw`: go to RD_WAIT with beat_cnt = 0.
  - Write beat accept is `valid & ready & rw & data_valid & data_ready`: set beat_cnt = 1 and go to WR_BURST. If BEATS == 1, go to IDLE instead.
  - If the owner drops req_valid without being accepted, return to IDLE. The picker pointer is not updated in this case.
- WR_BURST:
  - Forward the owner's fields.
  - Each accepted write beat increments beat_cnt.
  - The beat accepted with beat_cnt == BEATS-1 returns the block to IDLE.
- RD_WAIT:
  - Memory-side req valids are 0.
  - The owner's resp_valid = mem_resp_valid.
  - Each beat increments beat_cnt; the beat at beat_cnt == BEATS-1 returns the block to IDLE.
- A mem_resp_valid in any state other than RD_WAIT is dropped and sets err_stray_resp. It is not forwarded to either requester.
- beat_cnt wraps to 0 whenever the block returns to IDLE.
- A requester asserting valid while the other owns the bus is held with ready = 0. That request is arbitrated on the next IDLE.

## Timing
- Arbitration latency is 1 cycle. A request seen in IDLE at cycle N can first be accepted at cycle N+1 (CMD).
- Back-to-back transactions from different requesters are separated by 1 IDLE cycle.
- A read occupies the bus from command accept until the BEATS-th response beat.
- Response forwarding is combinational: resp_valid and resp_data reach the owner in the same cycle they arrive from memory.
- Reset values:
  - state = IDLE, owner = 0, beat_cnt = 0, picker pointer = dc-first, err_stray_resp = 0.
  - All ready, valid and resp_valid outputs are 0 during reset and in IDLE.
- Reset asserted mid-transaction aborts it immediately. No further beats are forwarded to either requester.
- An `ic_` request and a `dc_` request arriving in the same cycle are resolved by the picker only. No request is lost.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration.
  - The pointer flips to the other requester after each completed transaction.
  - On simultaneous requests, the requester that did not win last is granted.
- Not defined: fixed priority, dc always wins a simultaneous request. The pointer register is absent.

## Structure
- `const.vh` gets:
  - `MEM_ARB_BEATS`
  - state encodings `MEM_ARB_IDLE`, `MEM_ARB_CMD`, `MEM_ARB_RD_WAIT`, `MEM_ARB_WR_BURST`
  - requester IDs `MEM_ARB_IC = 0`, `MEM_ARB_DC = 1`
- One sub-module, `arb_pick2`: a 2-way picker (requests, pointer → grant). It contains the `MEM_ARBITER_RR_EN` logic.
- All muxing and counters live in `mem_arbiter`.

## Test plan
- Lone ic read:
  - Stimulus: ic read of addr 0x0000040; memory returns 4 beats with data 0x1…0x4 starting 3 cycles after accept.
  - Required: only ic_mem_resp_valid pulses 4 times with 0x1…0x4; dc_mem_resp_valid stays 0; block is back in IDLE the cycle after beat 4.
- Simultaneous requests, MEM_ARBITER_RR_EN undefined:
  - Stimulus: ic read and dc write (addr 0x123) arrive in the same cycle.
  - Required: dc is granted and its 4 data beats appear on memory with mask 0xFFFF; ic ready stays 0 until dc completes; ic is then accepted 1 IDLE cycle later.
- Simultaneous requests, MEM_ARBITER_RR_EN defined:
  - Stimulus: both requesters continuously request reads for 4 transactions.
  - Required: grants alternate dc, ic, dc, ic.
- Write backpressure:
  - Stimulus: mem_req_data_ready low for 2 cycles in the middle of a dc write.
  - Required: beat_cnt holds; exactly 4 beats are accepted; data order is unchanged.
- Stray response:
  - Stimulus: mem_resp_valid pulsed while in IDLE.
  - Required: no requester resp_valid; err_stray_resp = 1 and stays set until reset.
- Reset mid-read:
  - Stimulus: reset asserted after beat 2 of an ic read.
  - Required: the next cycle is IDLE with all outputs 0; beats 3–4 are not forwarded; the first post-reset simultaneous request is granted to dc.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: beat count,
// FSM state encoding and requester IDs.
package mem_arbiter_pkg;

  localparam int unsigned MEM_ARB_BEATS = 4;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE     = 2'd0,
    MEM_ARB_CMD      = 2'd1,
    MEM_ARB_RD_WAIT  = 2'd2,
    MEM_ARB_WR_BURST = 2'd3
  } arb_state_t;

  localparam logic MEM_ARB_IC = 1'b0;
  localparam logic MEM_ARB_DC = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick2.sv
// Two-way grant picker for mem_arbiter.
// Optional feature macro: MEM_ARBITER_RR_EN (round-robin via pointer input);
// without it dc wins every simultaneous request.
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,   // bit MEM_ARB_IC = icache, bit MEM_ARB_DC = dcache
`ifdef MEM_ARBITER_RR_EN
  input  logic       ptr,   // requester preferred on a tie
`endif
  output logic       grant
);

  // Resolve the winning requester; result only matters when some req is set
  always_comb begin
    grant = MEM_ARB_IC;
`ifdef MEM_ARBITER_RR_EN
    if (req[MEM_ARB_IC] && req[MEM_ARB_DC]) begin
      grant = ptr;
    end else if (req[MEM_ARB_DC]) begin
      grant = MEM_ARB_DC;
    end
`else
    if (req[MEM_ARB_DC] || !req[MEM_ARB_IC]) begin
      grant = MEM_ARB_DC;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory interface between icache (ic_) and dcache (dc_).
// Grants a whole line transaction at a time: read command + BEATS response
// beats, or BEATS write beats. Optional feature macro: MEM_ARBITER_RR_EN
// selects round-robin arbitration; otherwise dc has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 28,
  parameter int unsigned DATA_BITS     = 128,
  parameter int unsigned BEATS         = MEM_ARB_BEATS
) (
  input  logic                     clk,
  input  logic                     reset,
  // icache requester
  input  logic                     ic_mem_req_valid,
  output logic                     ic_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr,
  input  logic                     ic_mem_req_rw,
  input  logic                     ic_mem_req_data_valid,
  output logic                     ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]     ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0]   ic_mem_req_data_mask,
  output logic                     ic_mem_resp_valid,
  output logic [DATA_BITS-1:0]     ic_mem_resp_data,
  // dcache requester
  input  logic                     dc_mem_req_valid,
  output logic                     dc_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr,
  input  logic                     dc_mem_req_rw,
  input  logic                     dc_mem_req_data_valid,
  output logic                     dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]     dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0]   dc_mem_req_data_mask,
  output logic                     dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]     dc_mem_resp_data,
  // memory side
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [DATA_BITS-1:0]     mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [DATA_BITS-1:0]     mem_resp_data,
  output logic                     err_stray_resp
);

  localparam int unsigned       CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t             state;
  logic                   owner;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   grant;

  logic                   own_valid;
  logic                   own_rw;
  logic                   own_data_valid;
  logic [MEM_ADDR_BITS-1:0] own_addr;
  logic [DATA_BITS-1:0]   own_data;
  logic [DATA_BITS/8-1:0] own_mask;

  logic                   fwd;
  logic                   rd_phase;
  logic                   ic_sel;
  logic                   dc_sel;
  logic                   rd_accept;
  logic                   wr_accept;
  logic                   wr_beat;
  logic                   txn_done;

`ifdef MEM_ARBITER_RR_EN
  logic                   ptr;

  arb_pick2 u_pick (
    .req   ({dc_mem_req_valid, ic_mem_req_valid}),
    .ptr   (ptr),
    .grant (grant)
  );
`else
  arb_pick2 u_pick (
    .req   ({dc_mem_req_valid, ic_mem_req_valid}),
    .grant (grant)
  );
`endif

  // Select the current owner's request fields
  always_comb begin
    if (owner == MEM_ARB_DC) begin
      own_valid      = dc_mem_req_valid;
      own_rw         = dc_mem_req_rw;
      own_data_valid = dc_mem_req_data_valid;
      own_addr       = dc_mem_req_addr;
      own_data       = dc_mem_req_data_bits;
      own_mask       = dc_mem_req_data_mask;
    end else begin
      own_valid      = ic_mem_req_valid;
      own_rw         = ic_mem_req_rw;
      own_data_valid = ic_mem_req_data_valid;
      own_addr       = ic_mem_req_addr;
      own_data       = ic_mem_req_data_bits;
      own_mask       = ic_mem_req_data_mask;
    end
  end

  // Reset gates every handshake so an aborted transaction forwards nothing
  assign fwd      = !reset && (state == MEM_ARB_CMD || state == MEM_ARB_WR_BURST);
  assign rd_phase = !reset && (state == MEM_ARB_RD_WAIT);
  assign ic_sel   = (owner == MEM_ARB_IC);
  assign dc_sel   = (owner == MEM_ARB_DC);

  assign mem_req_valid      = fwd & own_valid;
  assign mem_req_data_valid = fwd & own_data_valid;
  assign mem_req_addr       = own_addr;
  assign mem_req_rw         = own_rw;
  assign mem_req_data_bits  = own_data;
  assign mem_req_data_mask  = own_mask;

  assign ic_mem_req_ready      = fwd & ic_sel & mem_req_ready;
  assign ic_mem_req_data_ready = fwd & ic_sel & mem_req_data_ready;
  assign ic_mem_resp_valid     = rd_phase & ic_sel & mem_resp_valid;
  assign ic_mem_resp_data      = mem_resp_data;

  assign dc_mem_req_ready      = fwd & dc_sel & mem_req_ready;
  assign dc_mem_req_data_ready = fwd & dc_sel & mem_req_data_ready;
  assign dc_mem_resp_valid     = rd_phase & dc_sel & mem_resp_valid;
  assign dc_mem_resp_data      = mem_resp_data;

  // Once the command is taken, burst beats are paced by the data handshake alone
  assign rd_accept = own_valid & mem_req_ready & !own_rw;
  assign wr_accept = own_valid & mem_req_ready & own_rw & own_data_valid & mem_req_data_ready;
  assign wr_beat   = own_data_valid & mem_req_data_ready;

  assign txn_done = !reset && (
      (state == MEM_ARB_CMD      && wr_accept && (BEATS == 1)) ||
      (state == MEM_ARB_WR_BURST && wr_beat        && (beat_cnt == LAST_BEAT)) ||
      (state == MEM_ARB_RD_WAIT  && mem_resp_valid && (beat_cnt == LAST_BEAT)));

  // Transaction FSM, beat counter, owner latch and sticky stray-response flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= MEM_ARB_IDLE;
      owner          <= MEM_ARB_IC;
      beat_cnt       <= '0;
      err_stray_resp <= 1'b0;
    end else begin
      if (mem_resp_valid && state != MEM_ARB_RD_WAIT) begin
        err_stray_resp <= 1'b1;
      end
      case (state)
        MEM_ARB_IDLE: begin
          beat_cnt <= '0;
          if (ic_mem_req_valid || dc_mem_req_valid) begin
            owner <= grant;
            state <= MEM_ARB_CMD;
          end
        end
        MEM_ARB_CMD: begin
          if (!own_valid) begin
            state <= MEM_ARB_IDLE;
          end else if (rd_accept) begin
            beat_cnt <= '0;
            state    <= MEM_ARB_RD_WAIT;
          end else if (wr_accept) begin
            if (txn_done) begin
              beat_cnt <= '0;
              state    <= MEM_ARB_IDLE;
            end else begin
              beat_cnt <= CNT_W'(1);
              state    <= MEM_ARB_WR_BURST;
            end
          end
        end
        MEM_ARB_WR_BURST: begin
          if (wr_beat) begin
            if (txn_done) begin
              beat_cnt <= '0;
              state    <= MEM_ARB_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        MEM_ARB_RD_WAIT: begin
          if (mem_resp_valid) begin
            if (txn_done) begin
              beat_cnt <= '0;
              state    <= MEM_ARB_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          beat_cnt <= '0;
          state    <= MEM_ARB_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Prefer the requester that did not own the last completed transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= MEM_ARB_DC;
    end else if (txn_done) begin
      ptr <= ~owner;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table plus hand-written sequences
// for grant order, write backpressure and reset mid-read.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  logic         ic_valid = 1'b0, ic_rw = 1'b0, ic_dv = 1'b0;
  logic         dc_valid = 1'b0, dc_rw = 1'b0, dc_dv = 1'b0;
  logic [27:0]  ic_addr = 28'h0000040;
  logic [27:0]  dc_addr = 28'h0000123;
  logic [127:0] ic_data = 128'h1C;
  logic [127:0] dc_data = 128'hD0;
  logic [15:0]  ic_mask = 16'h0000;
  logic [15:0]  dc_mask = 16'hFFFF;
  logic         mem_rr = 1'b0, mem_dr = 1'b0, mem_rv = 1'b0;
  logic [127:0] mem_rd = '0;

  logic         ic_ready, ic_dready, ic_rv;
  logic         dc_ready, dc_dready, dc_rv;
  logic [127:0] ic_rdata, dc_rdata;
  logic         mem_req_valid, mem_req_rw, mem_req_data_valid;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         err;

  int unsigned  total = 0;
  int unsigned  bad = 0;

  mem_arbiter #(.MEM_ADDR_BITS(28), .DATA_BITS(128), .BEATS(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ic_mem_req_valid      (ic_valid),
    .ic_mem_req_ready      (ic_ready),
    .ic_mem_req_addr       (ic_addr),
    .ic_mem_req_rw         (ic_rw),
    .ic_mem_req_data_valid (ic_dv),
    .ic_mem_req_data_ready (ic_dready),
    .ic_mem_req_data_bits  (ic_data),
    .ic_mem_req_data_mask  (ic_mask),
    .ic_mem_resp_valid     (ic_rv),
    .ic_mem_resp_data      (ic_rdata),
    .dc_mem_req_valid      (dc_valid),
    .dc_mem_req_ready      (dc_ready),
    .dc_mem_req_addr       (dc_addr),
    .dc_mem_req_rw         (dc_rw),
    .dc_mem_req_data_valid (dc_dv),
    .dc_mem_req_data_ready (dc_dready),
    .dc_mem_req_data_bits  (dc_data),
    .dc_mem_req_data_mask  (dc_mask),
    .dc_mem_resp_valid     (dc_rv),
    .dc_mem_resp_data      (dc_rdata),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_rr),
    .mem_req_addr          (mem_req_addr),
    .mem_req_rw            (mem_req_rw),
    .mem_req_data_valid    (mem_req_data_valid),
    .mem_req_data_ready    (mem_dr),
    .mem_req_data_bits     (mem_req_data_bits),
    .mem_req_data_mask     (mem_req_data_mask),
    .mem_resp_valid        (mem_rv),
    .mem_resp_data         (mem_rd),
    .err_stray_resp        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // exp bits: {ic_rdy, ic_drdy, ic_rv, dc_rdy, dc_drdy, dc_rv, m_valid, m_rw, m_dvalid, err}
  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] ic;   // {valid, rw, data_valid}
    logic [2:0] dc;
    logic [2:0] mem;  // {req_ready, data_ready, resp_valid}
    logic [7:0] rd;
    logic [9:0] exp;
    logic       edc;  // expected owner when memory valid is expected
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic rst, input logic [2:0] ic,
                     input logic [2:0] dc, input logic [2:0] mem, input logic [7:0] rd,
                     input logic [9:0] exp, input logic edc);
    vec_t v;
    v.name = nm; v.rst = rst; v.ic = ic; v.dc = dc; v.mem = mem;
    v.rd = rd; v.exp = exp; v.edc = edc;
    vq.push_back(v);
  endtask

  initial begin
    logic [9:0]  act;
    logic        exp_g[4];
    int unsigned acc;
    int unsigned idx;
    int unsigned last_k;
    logic        found;

    // reset and lone ic read
    add("rst",        1, 3'b100, 3'b000, 3'b110, 8'h0, 10'b0000000000, 0);
    add("idle",       0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000000, 0);
    add("ic_req",     0, 3'b100, 3'b000, 3'b100, 8'h0, 10'b0000000000, 0);
    add("ic_cmd",     0, 3'b100, 3'b000, 3'b100, 8'h0, 10'b1000001000, 0);
    add("ic_wait1",   0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000000, 0);
    add("ic_wait2",   0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000000, 0);
    add("ic_beat1",   0, 3'b000, 3'b000, 3'b001, 8'h1, 10'b0010000000, 0);
    add("ic_beat2",   0, 3'b000, 3'b000, 3'b001, 8'h2, 10'b0010000000, 0);
    add("ic_beat3",   0, 3'b000, 3'b000, 3'b001, 8'h3, 10'b0010000000, 0);
    add("ic_beat4",   0, 3'b000, 3'b000, 3'b001, 8'h4, 10'b0010000000, 0);
    add("ic_done",    0, 3'b000, 3'b000, 3'b110, 8'h0, 10'b0000000000, 0);
    // simultaneous ic read / dc write
    add("sim_idle",   0, 3'b100, 3'b111, 3'b000, 8'h0, 10'b0000000000, 0);
    add("dc_wr1",     0, 3'b100, 3'b111, 3'b110, 8'h0, 10'b0001101110, 1);
    add("dc_wr2",     0, 3'b100, 3'b111, 3'b110, 8'h0, 10'b0001101110, 1);
    add("dc_wr3",     0, 3'b100, 3'b111, 3'b110, 8'h0, 10'b0001101110, 1);
    add("dc_wr4",     0, 3'b100, 3'b111, 3'b110, 8'h0, 10'b0001101110, 1);
    add("gap_idle",   0, 3'b100, 3'b000, 3'b110, 8'h0, 10'b0000000000, 0);
    add("ic_cmd2",    0, 3'b100, 3'b000, 3'b100, 8'h0, 10'b1000001000, 0);
    add("ic2_beat1",  0, 3'b000, 3'b000, 3'b001, 8'h5, 10'b0010000000, 0);
    add("ic2_beat2",  0, 3'b000, 3'b000, 3'b001, 8'h6, 10'b0010000000, 0);
    add("ic2_beat3",  0, 3'b000, 3'b000, 3'b001, 8'h7, 10'b0010000000, 0);
    add("ic2_beat4",  0, 3'b000, 3'b000, 3'b001, 8'h8, 10'b0010000000, 0);
    // stray response, then a dropped command
    add("stray",      0, 3'b000, 3'b000, 3'b001, 8'h9, 10'b0000000000, 0);
    add("err_set",    0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000001, 0);
    add("dc_req",     0, 3'b000, 3'b100, 3'b000, 8'h0, 10'b0000000001, 0);
    add("dc_drop",    0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000001, 0);
    add("drop_idle",  0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000001, 0);
    add("drop_req",   0, 3'b000, 3'b100, 3'b100, 8'h0, 10'b0000000001, 0);
    add("drop_cmd",   0, 3'b000, 3'b100, 3'b000, 8'h0, 10'b0000001001, 1);
    add("drop_again", 0, 3'b000, 3'b000, 3'b000, 8'h0, 10'b0000000001, 0);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      reset = vq[i].rst;
      {ic_valid, ic_rw, ic_dv} = vq[i].ic;
      {dc_valid, dc_rw, dc_dv} = vq[i].dc;
      {mem_rr, mem_dr, mem_rv} = vq[i].mem;
      mem_rd = {120'b0, vq[i].rd};
      @(negedge clk);
      act = {ic_ready, ic_dready, ic_rv, dc_ready, dc_dready, dc_rv,
             mem_req_valid, mem_req_rw & mem_req_valid, mem_req_data_valid, err};
      chk(vq[i].name, 128'(act), 128'(vq[i].exp));
      if (vq[i].exp[3]) begin
        chk({vq[i].name, "_addr"}, 128'(mem_req_addr), vq[i].edc ? 128'h123 : 128'h40);
        chk({vq[i].name, "_mask"}, 128'(mem_req_data_mask), vq[i].edc ? 128'hFFFF : 128'h0);
      end
      if (vq[i].exp[7]) chk({vq[i].name, "_data"}, ic_rdata, 128'(vq[i].rd));
      if (vq[i].exp[4]) chk({vq[i].name, "_data"}, dc_rdata, 128'(vq[i].rd));
    end

    // both requesters read continuously for 4 transactions
`ifdef MEM_ARBITER_RR_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int t = 0; t < 4; t++) begin
      found = 1'b0;
      for (int g = 0; g < 8 && !found; g++) begin
        @(posedge clk); #1;
        ic_valid = 1; ic_rw = 0; ic_dv = 0;
        dc_valid = 1; dc_rw = 0; dc_dv = 0;
        mem_rr = 1; mem_dr = 0; mem_rv = 0;
        @(negedge clk);
        if (mem_req_valid) found = 1'b1;
      end
      chk("grant_wait", 128'(mem_req_valid), 128'h1);
      chk("grant_owner", 128'({ic_ready, dc_ready}), exp_g[t] ? 128'h1 : 128'h2);
      chk("grant_addr", 128'(mem_req_addr), exp_g[t] ? 128'h123 : 128'h40);
      for (int b = 0; b < 4; b++) begin
        @(posedge clk); #1;
        mem_rr = 0; mem_rv = 1; mem_rd = 128'(16 * t + b);
        @(negedge clk);
        chk("grant_resp", 128'({ic_rv, dc_rv}), exp_g[t] ? 128'h1 : 128'h2);
      end
    end

    // dc write with two stalled data cycles in the middle
    acc = 0; idx = 0; last_k = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      ic_valid = 0; mem_rv = 0;
      dc_valid = (idx < 4); dc_rw = 1; dc_dv = (idx < 4);
      dc_data = 128'hA0 + 128'(idx);
      mem_rr = 1; mem_dr = !(k == 2 || k == 3);
      @(negedge clk);
      chk("wr_bus_busy", 128'(mem_req_valid), 128'((k >= 1) && (k <= 6)));
      if (mem_req_valid && mem_req_data_valid && mem_dr) begin
        chk("wr_beat_data", mem_req_data_bits, 128'hA0 + 128'(acc));
        chk("wr_beat_mask", 128'(mem_req_data_mask), 128'hFFFF);
        acc++;
        last_k = k;
      end
      if (dc_dready && dc_dv) idx++;
    end
    chk("wr_beat_count", 128'(acc), 128'd4);
    chk("wr_last_cycle", 128'(last_k), 128'd6);

    // ic read aborted by reset after beat 2
    @(posedge clk); #1;
    dc_valid = 0; dc_dv = 0; dc_rw = 0;
    ic_valid = 1; ic_rw = 0; mem_rr = 1; mem_dr = 0; mem_rv = 0;
    @(negedge clk);
    chk("err_sticky", 128'(err), 128'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_cmd", 128'(ic_ready), 128'h1);
    @(posedge clk); #1;
    ic_valid = 0; mem_rv = 1; mem_rd = 128'h11;
    @(negedge clk);
    chk("rr_beat1", 128'({ic_rv, dc_rv}), 128'h2);
    @(posedge clk); #1;
    mem_rd = 128'h12;
    @(negedge clk);
    chk("rr_beat2", 128'({ic_rv, dc_rv}), 128'h2);
    @(posedge clk); #1;
    reset = 1; mem_rd = 128'h13;
    @(negedge clk);
    chk("rst_beat3", 128'({ic_rv, dc_rv, ic_ready, dc_ready, mem_req_valid}), 128'h0);
    @(posedge clk); #1;
    reset = 0; mem_rd = 128'h14;
    @(negedge clk);
    chk("rst_beat4", 128'({ic_rv, dc_rv, ic_ready, dc_ready, mem_req_valid, err}), 128'h0);
    @(posedge clk); #1;
    mem_rv = 0; ic_valid = 1; dc_valid = 1;
    @(negedge clk);
    chk("post_rst_idle", 128'({ic_ready, dc_ready, mem_req_valid, err}), 128'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_grant", 128'({ic_ready, dc_ready}), 128'h1);
    @(posedge clk); #1;
    ic_valid = 0; dc_valid = 0; mem_rr = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
